// File: rtl/color_pkg.sv
// Shared types and constants for the UART colour frame loader.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package color_pkg;

    // Frame parser states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // Number of colour bytes carried between the sync byte and the checksum
    localparam int PAYLOAD_BYTES = 12;

    // Default frame start marker
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Width of the shadow buffer that collects one frame's payload
    localparam int SHADOW_BITS = PAYLOAD_BYTES * 8;

    // Bytes per quadrant colour (R, G, B)
    localparam int QUAD_BYTES = 3;

    // Payload byte 0 (R0) sits in the top byte of the shadow buffer, so
    // quadrant q is the q-th 24-bit slice counted from the top.
    function automatic logic [23:0] quad_color(input logic [SHADOW_BITS-1:0] sh,
                                               input int q);
        return sh[SHADOW_BITS-1-24*q -: 24];
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle watchdog: counts clocks while running without a byte strobe.
// Latency: expired is combinational from the count; it asserts in the cycle the count sits at the limit.
// Backpressure: none; kick (a received byte) always wins over expiry in the same cycle.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Idle counter: held at zero while not running or when a byte arrives,
    // otherwise counts up and parks at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || kick) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    // A byte arriving on the threshold cycle suppresses the timeout.
    assign expired = run && !kick && (count == LIMIT);

endmodule

// File: rtl/color_loader.sv
// Parses UART frames (sync, 12 colour bytes, XOR checksum) into four 24-bit quadrant colours.
// Latency: rgb0..rgb3 and color_valid update on the edge that samples a correct checksum byte.
// Backpressure: none; rx_valid is a strobe that is never stalled, stray bytes in IDLE are dropped.
module color_loader
    import color_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [23:0] rgb0,
    output logic [23:0] rgb1,
    output logic [23:0] rgb2,
    output logic [23:0] rgb3,
    output logic        color_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             idx;
    logic [7:0]             xor_acc;
    logic [SHADOW_BITS-1:0] shadow;

    logic frame_start;
    logic accept;
    logic commit;
    logic cks_bad;
    logic tmo;
    logic expired;

    // Idle watchdog runs only while a frame is open; every byte kicks it.
    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .kick    (rx_valid),
        .expired (expired)
    );

    assign busy = (state == ST_PAYLOAD) || (state == ST_CHECK);

    // Next-state and event decode; a sync value inside a frame is plain data.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        cks_bad     = 1'b0;
        tmo         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    frame_start = 1'b1;
                    state_nxt   = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_CHECK;
                    end
                end else if (expired) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    state_nxt = ST_IDLE;
                    if (rx_data == xor_acc) begin
                        commit = 1'b1;
                    end else begin
                        cks_bad = 1'b1;
                    end
                end else if (expired) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte index and running checksum; both restart on every sync byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            xor_acc <= '0;
        end else if (frame_start) begin
            idx     <= '0;
            xor_acc <= '0;
        end else if (accept) begin
            idx     <= idx + 4'd1;
            xor_acc <= xor_acc ^ rx_data;
        end
    end

    // Shadow buffer collects payload bytes so a partial frame never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (accept) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (idx == 4'(i)) begin
                    shadow[SHADOW_BITS-1-8*i -: 8] <= rx_data;
                end
            end
        end
    end

    // Visible colours change only when a frame's checksum matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb0 <= '0;
            rgb1 <= '0;
            rgb2 <= '0;
            rgb3 <= '0;
        end else if (commit) begin
            rgb0 <= quad_color(shadow, 0);
            rgb1 <= quad_color(shadow, 1);
            rgb2 <= quad_color(shadow, 2);
            rgb3 <= quad_color(shadow, 3);
        end
    end

    // One-cycle status pulses; commit and error are mutually exclusive by decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            color_valid <= commit;
            frame_err   <= cks_bad | tmo;
        end
    end

endmodule
